param_updown_counter: RTL and testbench
=======================================

PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the two's-complement width of a, b and q (WIDTH >= 2).
REQ-002 Parameter CNT_W, default 4, SHALL set the width of the overflow event counter ovf_count (CNT_W >= 1).
REQ-003 Parameter BOUNCE, default 0, SHALL when set to 1 make every overflow reverse the effective count direction.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-006 up  input  1  SHALL request q + b.
REQ-007 dn  input  1  SHALL request q - b.
REQ-008 ld  input  1  SHALL load a into q.
REQ-009 clr  input  1  SHALL clear ovf_count.
REQ-010 a  input  WIDTH signed  SHALL be the load value.
REQ-011 b  input  WIDTH signed  SHALL be the step value.
REQ-012 q  output  WIDTH signed  SHALL be the registered count.
REQ-013 ovf  output  1  SHALL be a registered one-cycle overflow pulse.
REQ-014 ovf_count  output  CNT_W  SHALL be the registered number of overflows since rst or clr, saturating at all-ones.
REQ-015 rev  output  1  SHALL be the registered direction-reversal state (constant 0 when BOUNCE=0).

Function
REQ-016 Per-edge priority for q SHALL be: rst > ld > count > hold.
REQ-017 Effective direction SHALL be eu = up ^ rev and ed = dn ^ rev.
REQ-018 If eu=1 and ed=0, the exact result SHALL be q + b, computed in WIDTH+1 bits with sign extension.
REQ-019 If eu=0 and ed=1, the exact result SHALL be q - b, computed in WIDTH+1 bits; b = -2^(WIDTH-1) SHALL be handled without error.
REQ-020 If eu equals ed (both 0 or both 1), q SHALL hold and ovf SHALL be 0.
REQ-021 An overflow SHALL be flagged when the exact result lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-022 On overflow, q SHALL take the low WIDTH bits of the exact result (wrap), unless the saturation feature is compiled in.
REQ-023 ovf SHALL be 1 in exactly the cycle after an overflowing operation, together with the updated q (single-cycle latency); otherwise 0.
REQ-024 On each overflow, ovf_count SHALL increment by 1 unless it is all-ones, in which case it holds.
REQ-025 clr SHALL force ovf_count to 0 and take priority over a simultaneous increment.
REQ-026 With BOUNCE=1, rev SHALL toggle on each overflow; the new direction applies from the next operation.
REQ-027 ld SHALL set q <= a, set rev <= 0, set ovf <= 0, and leave ovf_count unchanged.
REQ-028 clr SHALL NOT affect q, rev or ovf.

Reset
REQ-029 On rst=1 at a rising edge: q=0, ovf=0, ovf_count=0, rev=0, overriding ld, clr, up and dn.
REQ-030 rst asserted mid-sequence SHALL discard any operation in that cycle; no ovf pulse SHALL follow.

Configuration
REQ-031 Macro UDC_SATURATE_EN defined: on overflow, q SHALL clamp to 2^(WIDTH-1)-1 for positive results and -2^(WIDTH-1) for negative results; ovf, ovf_count and rev behave as without the macro.
REQ-032 Macro UDC_SATURATE_EN undefined: on overflow, q SHALL wrap per REQ-022.

Verification (WIDTH=8, CNT_W=4)
REQ-033 rst=1 for one edge after random activity -> q=0, ovf=0, ovf_count=0, rev=0.
REQ-034 ld a=100; then up b=27 -> q=127, ovf=0; then up b=1 -> q=-128, ovf=1, ovf_count=1 (saturate build: q=127).
REQ-035 ld a=0; then dn b=-128 -> overflow: q=-128 (saturate build: q=127), ovf=1.
REQ-036 BOUNCE=1, ld a=120; then up b=10 -> overflow, rev=1; then up b=10 -> q decreases by 10; ovf low on the second step.
REQ-037 up=dn=1 with b=5 -> q holds, ovf=0; 16 forced overflows -> ovf_count=15 (held); clr concurrent with an overflow -> ovf_count=0, ovf=1.

Source files
------------

// File: rtl/param_updown_counter.sv
// ---------------------------------------------------------------------------
// param_updown_counter
//   Signed up/down counter with overflow detection, a saturating overflow
//   event counter and an optional "bounce" mode where every overflow reverses
//   the effective count direction.
//
//   Optional feature macro: UDC_SATURATE_EN
//     defined   -> on overflow q clamps to the most positive/negative value
//     undefined -> on overflow q wraps (low WIDTH bits of the exact result)
//
// Parameters
//   WIDTH   two's-complement width of a, b, q (>= 2)
//   CNT_W   width of ovf_count (>= 1)
//   BOUNCE  1: each overflow toggles rev (direction reversal)
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   up, dn     count requests (q + b / q - b), XORed with rev
//   ld         load a into q (clears rev and ovf)
//   clr        clear ovf_count
//   a          load value (signed)
//   b          step value (signed)
//   q          registered count (signed)
//   ovf        registered one-cycle overflow pulse
//   ovf_count  registered saturating overflow event count
//   rev        registered direction-reversal state
// ---------------------------------------------------------------------------
module param_updown_counter #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned CNT_W  = 4,
    parameter int unsigned BOUNCE = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    up,
    input  logic                    dn,
    input  logic                    ld,
    input  logic                    clr,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] q,
    output logic                    ovf,
    output logic        [CNT_W-1:0] ovf_count,
    output logic                    rev
);

    localparam int unsigned EXT_W = WIDTH + 1;

    localparam logic [WIDTH-1:0] Q_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] Q_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] q_q,   q_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rev_q, rev_d;

    logic             eff_up;
    logic             eff_dn;
    logic             add_op;
    logic             sub_op;
    logic [EXT_W-1:0] q_ext;
    logic [EXT_W-1:0] b_ext;
    logic [EXT_W-1:0] res;
    logic             res_ovf;

    // Exact arithmetic in WIDTH+1 bits; overflow when the two top bits differ.
    always_comb begin
        eff_up  = up ^ rev_q;
        eff_dn  = dn ^ rev_q;
        add_op  = eff_up & ~eff_dn;
        sub_op  = ~eff_up & eff_dn;
        q_ext   = {q_q[WIDTH-1], q_q};
        b_ext   = {b[WIDTH-1], b};
        res     = add_op ? EXT_W'(q_ext + b_ext) : EXT_W'(q_ext - b_ext);
        res_ovf = (add_op | sub_op) & (res[WIDTH] ^ res[WIDTH-1]);
    end

    // Next-state: ld beats counting; clr beats the overflow increment.
    always_comb begin
        q_d   = q_q;
        ovf_d = 1'b0;
        cnt_d = cnt_q;
        rev_d = rev_q;

        if (ld) begin
            q_d   = a;
            rev_d = 1'b0;
        end else if (add_op | sub_op) begin
            q_d = res[WIDTH-1:0];
            if (res_ovf) begin
`ifdef UDC_SATURATE_EN
                // Sign of the exact result selects the clamp rail.
                q_d = res[WIDTH] ? Q_MIN : Q_MAX;
`endif
                ovf_d = 1'b1;
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                rev_d = ~rev_q;
            end
        end

        if (clr) begin
            cnt_d = '0;
        end

        if (BOUNCE == 0) begin
            rev_d = 1'b0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
            rev_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
            rev_q <= rev_d;
        end
    end

    assign q         = q_q;
    assign ovf       = ovf_q;
    assign ovf_count = cnt_q;
    assign rev       = rev_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_param_updown_counter
//   Directed self-checking bench for param_updown_counter (WIDTH=8, CNT_W=4).
//   Two instances share stimulus: dut (BOUNCE=0) and dut_b (BOUNCE=1).
// ---------------------------------------------------------------------------
module tb_param_updown_counter;

`ifdef UDC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              up, dn, ld, clr;
    logic signed [7:0] a, b;

    logic signed [7:0] q,   q_b;
    logic              ovf, ovf_b;
    logic        [3:0] cnt, cnt_b;
    logic              rev, rev_b;

    logic signed [7:0] eq;
    int                checks;
    int                errors;

    param_updown_counter #(.WIDTH(8), .CNT_W(4), .BOUNCE(0)) dut (
        .clk(clk), .rst(rst), .up(up), .dn(dn), .ld(ld), .clr(clr),
        .a(a), .b(b), .q(q), .ovf(ovf), .ovf_count(cnt), .rev(rev)
    );

    param_updown_counter #(.WIDTH(8), .CNT_W(4), .BOUNCE(1)) dut_b (
        .clk(clk), .rst(rst), .up(up), .dn(dn), .ld(ld), .clr(clr),
        .a(a), .b(b), .q(q_b), .ovf(ovf_b), .ovf_count(cnt_b), .rev(rev_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus, then sample 1 time unit after the edge.
    task automatic drive(input logic u, input logic d, input logic l,
                         input logic c, input int av, input int bv);
        up  = u;
        dn  = d;
        ld  = l;
        clr = c;
        a   = 8'(av);
        b   = 8'(bv);
        @(posedge clk);
        #1;
        up = 1'b0; dn = 1'b0; ld = 1'b0; clr = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 77, 5);
        rst = 1'b0;
        checks++;
        if ({q, ovf, cnt, rev} !== 14'd0) begin
            errors++;
            $display("FAIL reset dut: q=%0d ovf=%b cnt=%0d rev=%b, want all 0", q, ovf, cnt, rev);
        end
        checks++;
        if ({q_b, ovf_b, cnt_b, rev_b} !== 14'd0) begin
            errors++;
            $display("FAIL reset dut_b: q=%0d ovf=%b cnt=%0d rev=%b, want all 0", q_b, ovf_b, cnt_b, rev_b);
        end
    endtask

    task automatic test_add_overflow();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 100, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 27);
        checks++;
        if (q !== 8'sd127 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL add_127: q=%0d ovf=%b, want q=127 ovf=0", q, ovf);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 1);
        eq = SAT ? 8'sd127 : -8'sd128;
        checks++;
        if (q !== eq || ovf !== 1'b1 || cnt !== 4'd1) begin
            errors++;
            $display("FAIL add_ovf: q=%0d ovf=%b cnt=%0d, want q=%0d ovf=1 cnt=1", q, ovf, cnt, eq);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        checks++;
        if (q !== eq || ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_pulse: q=%0d ovf=%b, want q=%0d ovf=0", q, ovf, eq);
        end
    endtask

    task automatic test_sub();
        // 0 - (-128) = +128 overflows
        drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0, -128);
        eq = SAT ? 8'sd127 : -8'sd128;
        checks++;
        if (q !== eq || ovf !== 1'b1 || cnt !== 4'd2) begin
            errors++;
            $display("FAIL sub_min_ovf: q=%0d ovf=%b cnt=%0d, want q=%0d ovf=1 cnt=2", q, ovf, cnt, eq);
        end
        // plain subtract, then subtracting -128 without overflow
        drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 5);
        checks++;
        if (q !== -8'sd5 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL sub_plain: q=%0d ovf=%b, want q=-5 ovf=0", q, ovf);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0, -128);
        checks++;
        if (q !== 8'sd123 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL sub_min_ok: q=%0d ovf=%b, want q=123 ovf=0", q, ovf);
        end
        // -100 - 50 = -150 overflows negative
        drive(1'b0, 1'b0, 1'b1, 1'b0, -100, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 50);
        eq = SAT ? -8'sd128 : 8'sd106;
        checks++;
        if (q !== eq || ovf !== 1'b1 || cnt !== 4'd3) begin
            errors++;
            $display("FAIL sub_neg_ovf: q=%0d ovf=%b cnt=%0d, want q=%0d ovf=1 cnt=3", q, ovf, cnt, eq);
        end
    endtask

    task automatic test_hold_and_priority();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 40, 0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 5);
        checks++;
        if (q !== 8'sd40 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL hold_both: q=%0d ovf=%b, want q=40 ovf=0", q, ovf);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 5);
        checks++;
        if (q !== 8'sd40 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL hold_none: q=%0d ovf=%b, want q=40 ovf=0", q, ovf);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 5, 3);
        checks++;
        if (q !== 8'sd5 || ovf !== 1'b0 || cnt !== 4'd3) begin
            errors++;
            $display("FAIL ld_priority: q=%0d ovf=%b cnt=%0d, want q=5 ovf=0 cnt=3", q, ovf, cnt);
        end
    endtask

    task automatic test_bounce();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 120, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 100);
        eq = SAT ? 8'sd127 : -8'sd36;
        checks++;
        if (q_b !== eq || ovf_b !== 1'b1 || rev_b !== 1'b1) begin
            errors++;
            $display("FAIL bounce_ovf: q=%0d ovf=%b rev=%b, want q=%0d ovf=1 rev=1", q_b, ovf_b, rev_b, eq);
        end
        checks++;
        if (rev !== 1'b0 || q !== eq || ovf !== 1'b1) begin
            errors++;
            $display("FAIL nobounce_rev: q=%0d ovf=%b rev=%b, want q=%0d ovf=1 rev=0", q, ovf, rev, eq);
        end
        // up now subtracts on the bounce instance
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 10);
        eq = SAT ? 8'sd117 : -8'sd46;
        checks++;
        if (q_b !== eq || ovf_b !== 1'b0 || rev_b !== 1'b1) begin
            errors++;
            $display("FAIL bounce_dir: q=%0d ovf=%b rev=%b, want q=%0d ovf=0 rev=1", q_b, ovf_b, rev_b, eq);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 5);
        checks++;
        if (q_b !== eq || ovf_b !== 1'b0 || rev_b !== 1'b1) begin
            errors++;
            $display("FAIL bounce_hold: q=%0d ovf=%b rev=%b, want q=%0d ovf=0 rev=1", q_b, ovf_b, rev_b, eq);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 3, 0);
        checks++;
        if (q_b !== 8'sd3 || rev_b !== 1'b0) begin
            errors++;
            $display("FAIL bounce_ld: q=%0d rev=%b, want q=3 rev=0", q_b, rev_b);
        end
    endtask

    task automatic test_count_saturate();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 127, 0);
            drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 1);
            if (i == 15) begin
                checks++;
                if (cnt !== 4'd15 || ovf !== 1'b1) begin
                    errors++;
                    $display("FAIL cnt_15: cnt=%0d ovf=%b, want cnt=15 ovf=1", cnt, ovf);
                end
            end
        end
        checks++;
        if (cnt !== 4'd15 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL cnt_held: cnt=%0d ovf=%b, want cnt=15 ovf=1", cnt, ovf);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 127, 0);
        checks++;
        if (cnt !== 4'd15 || q !== 8'sd127) begin
            errors++;
            $display("FAIL ld_keeps_cnt: cnt=%0d q=%0d, want cnt=15 q=127", cnt, q);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 0, 1);
        eq = SAT ? 8'sd127 : -8'sd128;
        checks++;
        if (cnt !== 4'd0 || ovf !== 1'b1 || q !== eq) begin
            errors++;
            $display("FAIL clr_vs_ovf: cnt=%0d ovf=%b q=%0d, want cnt=0 ovf=1 q=%0d", cnt, ovf, q, eq);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        checks++;
        if (cnt !== 4'd0 || ovf !== 1'b0 || q !== eq) begin
            errors++;
            $display("FAIL clr_only: cnt=%0d ovf=%b q=%0d, want cnt=0 ovf=0 q=%0d", cnt, ovf, q, eq);
        end
    endtask

    task automatic test_rst_mid();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 127, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 127, 0);
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 1);
        rst = 1'b0;
        checks++;
        if (q !== 8'sd0 || ovf !== 1'b0 || cnt !== 4'd0) begin
            errors++;
            $display("FAIL rst_mid: q=%0d ovf=%b cnt=%0d, want 0 0 0", q, ovf, cnt);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        checks++;
        if (q !== 8'sd0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_pulse: q=%0d ovf=%b, want q=0 ovf=0", q, ovf);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        up = 1'b0; dn = 1'b0; ld = 1'b0; clr = 1'b0;
        a = '0; b = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        test_reset();
        test_add_overflow();
        test_sub();
        test_hold_and_priority();
        test_bounce();
        test_count_saturate();
        test_rst_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
